// File: rtl/systolic_array_architecture.sv
// ---------------------------------------------------------------------------
// systolic_array_architecture
//   Output-stationary DIM x DIM systolic matrix multiplier, C = A * B.
//   Operands are read combinationally from the internal arrays mem_a and mem_b,
//   which the environment preloads. The result is written row-major into mem_c,
//   one element per cycle.
//   FSM sequence: IDLE -> FEED (3*DIM-2 cycles) -> WRITE (DIM*DIM cycles) -> DONE.
//
// Ports
//   init            start request; sampled only in IDLE or DONE
//   rst             synchronous, active-high reset; takes priority over init
//   complete        high while in DONE
//   clk             rising-edge clock
//   base_address_A  row-major base address of A in mem_a (latched on start)
//   base_address_B  row-major base address of B in mem_b (latched on start)
//   base_address_C  row-major base address of C in mem_c (latched on start)
//   All address arithmetic wraps modulo 256.
//
// Build option
//   SA_SIGNED_EN  when defined, A/B are two's-complement and products are
//                 sign-extended. When undefined, operands are unsigned.
// ---------------------------------------------------------------------------

// One processing element. It accumulates a_in*b_in and forwards both operands
// one cycle later: a_in goes east and b_in goes south.
module sa_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d, a_ext, b_ext;

`ifdef SA_SIGNED_EN
  assign a_ext = {{(ACC_W-DATA_W){a_in[DATA_W-1]}}, a_in};
  assign b_ext = {{(ACC_W-DATA_W){b_in[DATA_W-1]}}, b_in};
`else
  assign a_ext = {{(ACC_W-DATA_W){1'b0}}, a_in};
  assign b_ext = {{(ACC_W-DATA_W){1'b0}}, b_in};
`endif

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d   = a_in;
      b_d   = b_in;
      // Both operands are already extended to ACC_W, so the product and the
      // sum wrap modulo 2^ACC_W.
      acc_d = acc_q + a_ext * b_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
endmodule

module systolic_array_architecture #(
  parameter int DIM    = 5,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic       init,
  input  logic       rst,
  output logic       complete,
  input  logic       clk,
  input  logic [7:0] base_address_A,
  input  logic [7:0] base_address_B,
  input  logic [7:0] base_address_C
);
  typedef enum logic [1:0] {IDLE, FEED, WRITE, DONE} state_t;

  localparam int CNT_W = $clog2(DIM*DIM + 3*DIM);
  localparam int RC_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(3*DIM-3);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(DIM*DIM-1);
  localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(DIM-1);

  // Operand and result storage. The environment loads these arrays directly.
  logic [255:0][DATA_W-1:0] mem_a;
  logic [255:0][DATA_W-1:0] mem_b;
  logic [255:0][ACC_W-1:0]  mem_c;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // FEED cycle t, then WRITE element index
  logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
  logic [7:0]        base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic              clr, feed, wr_en;
  logic [7:0]        wr_addr;
  logic [ACC_W-1:0]  c_sel;

  logic [DIM-1:0][DATA_W-1:0]        a_edge, b_edge;
  logic [DIM-1:0][DIM:0][DATA_W-1:0] a_h;  // a_h[i][j] feeds PE(i,j)
  logic [DIM:0][DIM-1:0][DATA_W-1:0] b_v;  // b_v[i][j] feeds PE(i,j)
  logic [DIM-1:0][DIM-1:0][ACC_W-1:0] acc;

  // Skewed edge injection: row i receives A[i][t-i] and column j receives
  // B[t-j][j]. This skew makes A[i][k] and B[k][j] meet in PE(i,j) at
  // cycle t = i+j+k.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    for (int i = 0; i < DIM; i++) begin
      if (feed && int'(cnt_q) >= i && int'(cnt_q) - i < DIM)
        a_edge[i] = mem_a[8'(int'(base_a_q) + i*DIM + int'(cnt_q) - i)];
    end
    for (int j = 0; j < DIM; j++) begin
      if (feed && int'(cnt_q) >= j && int'(cnt_q) - j < DIM)
        b_edge[j] = mem_b[8'(int'(base_b_q) + (int'(cnt_q) - j)*DIM + j)];
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    assign a_h[i][0] = a_edge[i];
    for (genvar j = 0; j < DIM; j++) begin : g_col
      sa_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (feed),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end
  for (genvar j = 0; j < DIM; j++) begin : g_top
    assign b_v[0][j] = b_edge[j];
  end

  // The east and south edge outputs leave the array and are intentionally
  // dropped. mem_c is read only by the environment.
  logic [DIM-1:0][DATA_W-1:0] a_east;
  always_comb begin
    a_east = '0;
    for (int i = 0; i < DIM; i++) a_east[i] = a_h[i][DIM];
  end
  logic unused_sink;
  assign unused_sink = ^{a_east, b_v[DIM], mem_c};

  // C is contiguous in row-major order, so its address is base + element index.
  assign wr_addr = base_c_q + 8'(cnt_q);
  assign c_sel   = acc[row_q][col_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    clr      = 1'b0;
    feed     = 1'b0;
    wr_en    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        complete = (state_q == DONE);
        if (init) begin
          base_a_d = base_address_A;
          base_b_d = base_address_B;
          base_c_d = base_address_C;
          cnt_d    = '0;
          row_d    = '0;
          col_d    = '0;
          clr      = 1'b1;
          state_d  = FEED;
        end
      end
      FEED: begin
        feed = 1'b1;
        if (cnt_q == FEED_LAST) begin
          cnt_d   = '0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        // A reset in this cycle blocks the write, so mem_c keeps only the
        // elements written before the reset.
        wr_en = ~rst;
        if (col_q == RC_LAST) begin
          col_d = '0;
          row_d = (row_q == RC_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (cnt_q == WRITE_LAST) state_d = DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
    end
  end

  // The memories are never reset. mem_a and mem_b only hold their contents,
  // which the environment loads.
  always_ff @(posedge clk) begin
    mem_a <= mem_a;
    mem_b <= mem_b;
    if (wr_en) mem_c[wr_addr] <= c_sel;
  end
endmodule

// File: tb/tb_systolic_array_architecture.sv
module tb_systolic_array_architecture;
  localparam int DIM = 5;
  localparam int LAT = 1 + (3*DIM-2) + DIM*DIM;
  localparam int BOUND = 70;

  logic       clk = 1'b0;
  logic       rst, init, complete;
  logic [7:0] base_a, base_b, base_c;

  systolic_array_architecture #(.DIM(DIM), .DATA_W(8), .ACC_W(32)) dut (
    .init           (init),
    .rst            (rst),
    .complete       (complete),
    .clk            (clk),
    .base_address_A (base_a),
    .base_address_B (base_b),
    .base_address_C (base_c)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ma [256];
  logic [7:0]  mb [256];
  logic [31:0] exp_c [256];
  logic [31:0] cm [DIM*DIM];

  typedef struct {
    int          a_mode;  // 0 ramp, 1 identity, 2 ones, 3 0xFF, 4 random
    int          b_mode;
    int          ba, bb, bc;
    bit          use_chk;
    int          chk_addr;
    logic [31:0] chk_val;
  } vec_t;
  vec_t tbl [8];

  function automatic longint ext(input logic [7:0] v);
`ifdef SA_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic load(input bit is_a, input int mode, input int base);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        logic [7:0] v;
        int a;
        a = (base + r*DIM + c) % 256;
        case (mode)
          0: v = 8'(r*DIM + c);
          1: v = (r == c) ? 8'd1 : 8'd0;
          2: v = 8'd1;
          3: v = 8'hFF;
          default: v = 8'($urandom);
        endcase
        if (is_a) begin ma[a] = v; dut.mem_a[8'(a)] = v; end
        else      begin mb[a] = v; dut.mem_b[8'(a)] = v; end
      end
  endtask

  // Reference C = A*B computed directly from the row-major operand layout.
  task automatic model_compute(input int ba, input int bb);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < DIM; k++)
          s = s + 32'(ext(ma[(ba + i*DIM + k) % 256]) * ext(mb[(bb + k*DIM + j) % 256]));
        cm[i*DIM + j] = s;
      end
  endtask

  task automatic commit(input int bc, input int n);
    for (int e = 0; e < n; e++) exp_c[(bc + e) % 256] = cm[e];
  endtask

  task automatic check_mem(input string name);
    int shown;
    shown = 0;
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (dut.mem_c[8'(a)] !== exp_c[a]) begin
        errors++;
        if (shown < 6)
          $display("FAIL %s mem_c[%0d]: got %h, expected %h", name, a, dut.mem_c[8'(a)], exp_c[a]);
        shown++;
      end
    end
  endtask

  // Entered at a negedge. Pulses init, then watches complete at each negedge.
  // lat is the number of edges after the init-sampling edge up to the first
  // edge that sees complete high, or -1 if it never rises within BOUND.
  // An init pulse is injected before edges inj_a and inj_b, and a reset
  // before edge rst_at (0 means none).
  task automatic run(input int inj_a, input int inj_b, input int rst_at, output int lat);
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    lat = -1;
    for (int k = 1; k <= BOUND; k++) begin
      @(negedge clk);
      init = 1'b0;
      rst  = 1'b0;
      if (complete) begin lat = k; break; end
      if (k == inj_a || k == inj_b) init = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
    init = 1'b0;
    rst  = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; init = 1'b0; base_a = '0; base_b = '0; base_c = '0;

    tbl[0] = '{0, 1, 0, 0, 0,   1'b1, 7,  32'd7};
    tbl[1] = '{2, 2, 0, 0, 0,   1'b1, 24, 32'd5};
    tbl[2] = '{2, 2, 0, 0, 250, 1'b1, 18, 32'd5};
`ifdef SA_SIGNED_EN
    tbl[3] = '{3, 2, 0, 0, 0,   1'b1, 0,  32'hFFFFFFFB};
`else
    tbl[3] = '{3, 2, 0, 0, 0,   1'b1, 0,  32'd1275};
`endif
    tbl[4] = '{4, 4, 240, 250, 30, 1'b0, 0, 32'd0};
    for (int v = 5; v < 8; v++)
      tbl[v] = '{4, 4, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b0, 0, 32'd0};

    repeat (3) @(negedge clk);
    check("reset_complete", complete, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_complete", complete, 0);

    for (int a = 0; a < 256; a++) begin
      exp_c[a] = 32'hC0DE0000 + 32'(a);
      dut.mem_c[8'(a)] = exp_c[a];
      ma[a] = 8'd0; mb[a] = 8'd0;
      dut.mem_a[8'(a)] = 8'd0; dut.mem_b[8'(a)] = 8'd0;
    end

    foreach (tbl[v]) begin
      load(1'b1, tbl[v].a_mode, tbl[v].ba);
      load(1'b0, tbl[v].b_mode, tbl[v].bb);
      base_a = 8'(tbl[v].ba); base_b = 8'(tbl[v].bb); base_c = 8'(tbl[v].bc);
      model_compute(tbl[v].ba, tbl[v].bb);
      run(0, 0, 0, lat);
      check($sformatf("vec%0d_latency", v), lat, LAT);
      commit(tbl[v].bc, DIM*DIM);
      check_mem($sformatf("vec%0d", v));
      if (tbl[v].use_chk)
        check($sformatf("vec%0d_const", v), dut.mem_c[8'(tbl[v].chk_addr)], tbl[v].chk_val);
    end

    // A second init from DONE reruns the job. The target is cleared first so
    // the rerun must write it again.
    load(1'b1, 2, 0); load(1'b0, 2, 0);
    base_a = 8'd0; base_b = 8'd0; base_c = 8'd100;
    model_compute(0, 0);
    run(0, 0, 0, lat);
    commit(100, DIM*DIM);
    check("rerun1_latency", lat, LAT);
    for (int e = 0; e < DIM*DIM; e++) begin
      exp_c[100 + e] = 32'd0;
      dut.mem_c[8'(100 + e)] = 32'd0;
    end
    run(0, 0, 0, lat);
    check("rerun2_latency", lat, LAT);
    commit(100, DIM*DIM);
    check_mem("rerun2");

    // init pulses during FEED and WRITE are ignored.
    load(1'b1, 4, 17); load(1'b0, 4, 201);
    base_a = 8'd17; base_b = 8'd201; base_c = 8'd60;
    model_compute(17, 201);
    run(6, 25, 0, lat);
    check("ign_init_latency", lat, LAT);
    commit(60, DIM*DIM);
    check_mem("ign_init");

    // A reset during FEED cycle 6 abandons the run without touching mem_c.
    load(1'b1, 4, 5); load(1'b0, 4, 9);
    base_a = 8'd5; base_b = 8'd9; base_c = 8'd150;
    run(0, 0, 7, lat);
    check("rst_feed_no_complete", lat, -1);
    check("rst_feed_complete_low", complete, 0);
    check_mem("rst_feed");
    model_compute(5, 9);
    run(0, 0, 0, lat);
    check("after_rst_latency", lat, LAT);
    commit(150, DIM*DIM);
    check_mem("after_rst");

    // A reset during WRITE keeps the 10 elements already written.
    load(1'b1, 4, 80); load(1'b0, 4, 120);
    base_a = 8'd80; base_b = 8'd120; base_c = 8'd200;
    model_compute(80, 120);
    run(0, 0, 24, lat);
    check("rst_write_no_complete", lat, -1);
    commit(200, 10);
    check_mem("rst_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_array_architecture.md
SYSTOLIC_ARRAY_ARCHITECTURE -- requirements
Module: systolic_array_architecture

Interface
REQ-001 SHALL have parameter DIM, default 5: matrix and array dimension, so the array is DIM x DIM.
REQ-002 SHALL have parameter DATA_W, default 8: width of the A and B operand elements.
REQ-003 SHALL have parameter ACC_W, default 32: width of the accumulator and of each C element.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port init, input, 1 bit: start request, sampled high while idle or done.
REQ-007 SHALL have port complete, output, 1 bit: result written, held high in DONE.
REQ-008 SHALL have ports base_address_A, base_address_B, base_address_C, input, 8 bits each: row-major matrix base addresses.
REQ-009 SHALL have port order (init, rst, complete, clk, base_address_A, base_address_B, base_address_C).
REQ-010 SHALL contain internal arrays mem_a and mem_b (256 x DATA_W) and mem_c (256 x ACC_W), preloadable and readable hierarchically by a bench.

Function
REQ-011 SHALL use FSM states IDLE, FEED and WRITE, plus DONE.
REQ-012 SHALL latch all three base addresses, clear all accumulators and pipeline registers, and enter FEED when init=1 in IDLE or DONE.
REQ-013 SHALL ignore init in FEED and WRITE.
REQ-014 In FEED, SHALL run t = 0 .. 3*DIM-3 (13 cycles at DIM=5), then enter WRITE.
REQ-015 In FEED cycle t, SHALL inject A[i][t-i] into the left edge of row i when 0 <= t-i < DIM, else 0.
REQ-016 In FEED cycle t, SHALL inject B[t-j][j] into the top edge of column j when 0 <= t-j < DIM, else 0.
REQ-017 SHALL address the operands as A[r][c] = mem_a[base_A + r*DIM + c] and B[r][c] = mem_b[base_B + r*DIM + c], read combinationally.
REQ-018 Each PE(i,j) SHALL per cycle do acc += a_in*b_in, register a_in to PE(i,j+1) and b_in to PE(i+1,j) (output-stationary).
REQ-019 SHALL truncate products and sums modulo 2^ACC_W.
REQ-020 In WRITE, SHALL write one element per cycle, C[i][j] to mem_c[base_C + i*DIM + j], in row-major order over DIM*DIM cycles, then enter DONE.
REQ-021 SHALL compute all addresses modulo 256 (wrap-around).
REQ-022 In DONE, SHALL hold complete=1 until init restarts or rst; complete SHALL be 0 in every other state.
REQ-023 SHALL assert complete exactly 1 + (3*DIM-2) + DIM*DIM cycles after the init-sampling edge (39 at DIM=5).

Reset
REQ-024 With rst=1 at a clock edge, SHALL force state IDLE, complete=0, and clear accumulators and pipeline registers to 0; rst SHALL take priority over init.
REQ-025 SHALL not clear mem_a, mem_b or mem_c on reset.
REQ-026 On reset mid-run, SHALL abandon the run; mem_c locations already written SHALL keep their values.

Configuration
REQ-027 Macro SA_SIGNED_EN: when defined, SHALL treat A/B as two's-complement and sign-extend the products; when undefined, SHALL treat operands as unsigned and zero-extend.

Verification
REQ-028 A = 0..24 row-major at base_A 0, B = identity at base_B 0, base_C 0, init pulse: SHALL give mem_c[0..24] = 0..24 with complete high 39 cycles later.
REQ-029 A and B all 1s: SHALL give every C = 5; second init from DONE SHALL rerun and give the same result.
REQ-030 base_C = 250: SHALL write C to 250..255 then 0..18 (wrap).
REQ-031 rst pulse during FEED cycle 6: SHALL give complete=0, IDLE and mem_c unchanged; subsequent init SHALL run normally.
REQ-032 init pulses during FEED/WRITE: SHALL be ignored, with completion timing unchanged.
REQ-033 A all 0xFF and B all 1: SHALL give C = -5 (0xFFFFFFFB) with SA_SIGNED_EN, and 1275 without.
